// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's load/store port.
// Accepts one word-addressed request at a time (valid/ready), waits
// WAIT_CYCLES wait states, then commits the store or returns load data
// together with a one-cycle response strobe.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_addr              byte address (must be word aligned, < 4*DEPTH)
//   req_wdata, req_be     store data and per-byte lane enables
//   rsp_valid             one-cycle response strobe
//   rsp_rdata, rsp_err    load data / access fault, held until next response
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic [AW-1:0] cur_idx;
  logic          cur_fault;
  logic          commit;
  logic          mem_we;

  always_comb begin
    accept = (state_q == S_IDLE) && req_valid;

    // With zero wait states the commit happens on the accepting edge, so the
    // request is taken straight from the inputs instead of the latched copy.
    cur_we    = accept ? req_we    : we_q;
    cur_addr  = accept ? req_addr  : addr_q;
    cur_wdata = accept ? req_wdata : wdata_q;
    cur_be    = accept ? req_be    : be_q;
    cur_idx   = cur_addr[AW+1:2];
    cur_fault = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);

    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      err_d   = cur_fault;
      rdata_d = (cur_fault || cur_we) ? '0 : mem[cur_idx];
    end

    // rst gate keeps a zero-wait request presented during reset from writing.
    mem_we = commit && cur_we && !cur_fault && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WAIT_CYCLES=2, instance B: WAIT_CYCLES=0
  logic        v_a = 1'b0, we_a = 1'b0, rdy_a, rv_a, err_a;
  logic [31:0] ad_a = '0, wd_a = '0, rd_a;
  logic [3:0]  be_a = '0;
  logic        v_b = 1'b0, we_b = 1'b0, rdy_b, rv_b, err_b;
  logic [31:0] ad_b = '0, wd_b = '0, rd_b;
  logic [3:0]  be_b = '0;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(v_a), .req_ready(rdy_a), .req_we(we_a),
    .req_addr(ad_a), .req_wdata(wd_a), .req_be(be_a),
    .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a));

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(v_b), .req_ready(rdy_b), .req_we(we_b),
    .req_addr(ad_b), .req_wdata(wd_b), .req_be(be_b),
    .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b));

  int   total = 0;
  int   bad   = 0;
  int   pulses_a = 0;
  exp_t sb[$];
  logic [31:0] model [256];

  always @(negedge clk) if (rv_a === 1'b1) pulses_a++;

  function automatic exp_t model_req(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    int unsigned idx;
    e.rdata = '0;
    e.err   = 1'b0;
    idx = int'(addr[9:2]);
    if (addr[1:0] != 2'b00 || addr >= 32'd1024) e.err = 1'b1;
    else if (we) begin
      for (int i = 0; i < 4; i++) if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
    end else e.rdata = model[idx];
    return e;
  endfunction

  // One request on instance A (W=2): latency, data, error, strobe width.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    int   n;
    exp_t e;
    logic [31:0] held;
    @(negedge clk);
    v_a = 1'b1; we_a = we; ad_a = addr; wd_a = wdata; be_a = be;
    n = 0;
    while (rdy_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (rdy_a !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout addr=%h ready=%b required=1", addr, rdy_a);
      v_a = 1'b0;
      return;
    end
    sb.push_back(model_req(we, addr, wdata, be));
    @(negedge clk);
    v_a = 1'b0;
    n = 1;
    while (rv_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL latency addr=%h got=%0d required=3", addr, n);
    end
    if (rv_a === 1'b1) begin
      e = sb.pop_front();
      total++;
      if (rd_a !== e.rdata || err_a !== e.err) begin
        bad++;
        $display("FAIL response addr=%h we=%b got rdata=%h err=%b required rdata=%h err=%b",
                 addr, we, rd_a, err_a, e.rdata, e.err);
      end
      held = rd_a;
      @(negedge clk);
      total++;
      if (rv_a !== 1'b0 || rd_a !== held || rdy_a !== 1'b1) begin
        bad++;
        $display("FAIL strobe_width addr=%h got valid=%b rdata=%h ready=%b required 0/%h/1",
                 addr, rv_a, rd_a, rdy_a, held);
      end
    end else begin
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    total++;
    if (rdy_a !== 1'b1 || rv_a !== 1'b0 || rd_a !== 32'h0 || err_a !== 1'b0 ||
        rdy_b !== 1'b1 || rv_b !== 1'b0 || rd_b !== 32'h0 || err_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got a=%b%b%h%b b=%b%b%h%b required ready=1 valid=0 rdata=0 err=0",
               rdy_a, rv_a, rd_a, err_a, rdy_b, rv_b, rd_b, err_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_load;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_req(1'b0, 32'h10, 32'h0, 4'h0);
    total++;
    if (model[4] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL model_word4 got=%h required=deadbeef", model[4]);
    end
  endtask

  task automatic test_byte_lanes;
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    do_req(1'b0, 32'h20, 32'h0, 4'hF);
    total++;
    if (rd_a !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL byte_lanes got=%h required=11bb33dd", rd_a);
    end
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    do_req(1'b0, 32'h20, 32'h0, 4'b0000);
  endtask

  task automatic test_faults;
    do_req(1'b1, 32'h0, 32'h12345678, 4'hF);
    do_req(1'b0, 32'h13, 32'h0, 4'hF);
    do_req(1'b1, 32'h400, 32'h55555555, 4'hF);
    do_req(1'b1, 32'h8000_0000, 32'h66666666, 4'hF);
    do_req(1'b0, 32'h0, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [4];
    logic [31:0] datas [4];
    logic        wes   [4];
    int   k;
    exp_t e;
    addrs[0] = 32'h40; datas[0] = 32'h01020304; wes[0] = 1'b1;
    addrs[1] = 32'h40; datas[1] = 32'h0;        wes[1] = 1'b0;
    addrs[2] = 32'h44; datas[2] = 32'hA5A55A5A; wes[2] = 1'b1;
    addrs[3] = 32'h44; datas[3] = 32'h0;        wes[3] = 1'b0;
    k = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      total++;
      if (rdy_b !== ((c % 2) == 0) || rv_b !== ((c % 2) == 1)) begin
        bad++;
        $display("FAIL b2b_pattern cyc=%0d got ready=%b valid=%b required ready=%0d valid=%0d",
                 c, rdy_b, rv_b, (c % 2) == 0, (c % 2) == 1);
      end
      if (rv_b === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL b2b_extra_response cyc=%0d got=1 required=0", c);
        end else begin
          e = sb.pop_front();
          total++;
          if (rd_b !== e.rdata || err_b !== e.err) begin
            bad++;
            $display("FAIL b2b_data cyc=%0d got=%h/%b required=%h/%b",
                     c, rd_b, err_b, e.rdata, e.err);
          end
        end
      end
      if (rdy_b === 1'b1) begin
        if (k < 4) begin
          v_b = 1'b1; we_b = wes[k]; ad_b = addrs[k]; wd_b = datas[k]; be_b = 4'hF;
          sb.push_back(model_req(wes[k], addrs[k], datas[k], 4'hF));
          k++;
        end else v_b = 1'b0;
      end
    end
    v_b = 1'b0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_missing got=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_abort;
    do_req(1'b1, 32'h8, 32'h0, 4'hF);
    do_req(1'b0, 32'h0, 32'h0, 4'hF);
    @(negedge clk);
    v_a = 1'b1; we_a = 1'b1; ad_a = 32'h8; wd_a = 32'hCAFEF00D; be_a = 4'hF;
    @(negedge clk);
    v_a = 1'b0;
    total++;
    if (rdy_a !== 1'b0) begin
      bad++;
      $display("FAIL abort_in_wait got ready=%b required=0", rdy_a);
    end
    rst = 1'b1;
    #1;
    total++;
    if (rdy_a !== 1'b1 || rv_a !== 1'b0 || rd_a !== 32'h0 || err_a !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset_outputs got %b/%b/%h/%b required 1/0/0/0",
               rdy_a, rv_a, rd_a, err_a);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (rdy_a !== 1'b1 || rv_a !== 1'b0) begin
      bad++;
      $display("FAIL abort_post_reset got ready=%b valid=%b required 1/0", rdy_a, rv_a);
    end
    do_req(1'b0, 32'h8, 32'h0, 4'hF);
  endtask

  task automatic test_random;
    int start;
    logic [31:0] a;
    for (int w = 0; w < 8; w++) do_req(1'b1, 32'h100 + 32'(4*w), $urandom, 4'hF);
    start = pulses_a;
    for (int i = 0; i < 20; i++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    total++;
    if (pulses_a - start !== 20) begin
      bad++;
      $display("FAIL pulse_count got=%0d required=20", pulses_a - start);
    end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_byte_lanes;
    test_faults;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
